layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Sequencing controller that drives one fully-connected neuron layer. It accepts a parallel input frame (the previous layer's concatenated neuron outputs) and shifts it word-by-word into the layer's shared `my_input`/`valid_input` bus. It then collects every neuron's `valid_output` pulse and captures that neuron's result, and finally presents the completed output frame to the next stage with a valid/ready handshake. One instance sits between each pair of layers in the network pipeline.

## Interface
- `NUM_IN`, 10: words per input frame; equals `num_weights` of the driven layer.
- `NUM_OUT`, 10: neurons in the driven layer.
- `DATA_WIDTH`, 16: bits per word.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input frame valid.
- `in_ready`  out  1  sequencer can accept a frame.
- `in_data`  in  NUM_IN*DATA_WIDTH  input frame; word k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `lyr_input`  out  DATA_WIDTH  to layer `my_input`.
- `lyr_valid_input`  out  1  to layer `valid_input`.
- `lyr_valid_output`  in  NUM_OUT  from layer `valid_output`; one pulse per neuron per frame.
- `lyr_neuron_out`  in  NUM_OUT*DATA_WIDTH  from layer `neuron_out`.
- `out_valid`  out  1  output frame valid.
- `out_ready`  in  1  downstream accepts the output frame.
- `out_data`  out  NUM_OUT*DATA_WIDTH  captured layer outputs, same packing as `lyr_neuron_out`.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky protocol-error flag.
- `perf_cycles`  out  32  cycle count of the last completed frame. Active only when the perf counter is enabled; see Configuration.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on `in_valid & in_ready`. `in_ready` is asserted only in IDLE.
  - SHIFT → WAIT after `NUM_IN` words have been issued.
  - WAIT → HOLD when the done-mask is all ones.
  - HOLD → IDLE on `out_valid & out_ready`.
- On accept, `in_data` is latched into a frame buffer. Later changes to `in_data` have no effect on the frame.
- SHIFT: a word index counts 0..NUM_IN-1. `lyr_input` is word[index] and `lyr_valid_input`=1 every cycle, with no gaps.
- Done-mask (NUM_OUT bits) is cleared on entry to SHIFT.
  - Each cycle, for every bit i with `lyr_valid_output[i]`=1 in SHIFT or WAIT: set mask[i] and capture `lyr_neuron_out` slice i into `out_data` slice i.
  - Multiple bits in the same cycle are all captured.
- `err` is set when any `lyr_valid_output` bit is high while in IDLE or HOLD, or when a bit is high whose mask bit is already set. A duplicate pulse does not overwrite the captured data. `err` clears only on `rst`.
- In HOLD, `out_data` is stable until the handshake completes.

## Timing
- Reset values:
  - state = IDLE, `in_ready`=1, `lyr_valid_input`=0, `lyr_input`=0.
  - `out_valid`=0, `out_data`=0, mask=0.
  - `busy`=0, `err`=0, `perf_cycles`=0.
- Accept at cycle T:
  - `lyr_valid_input` is high for cycles T+1 through T+NUM_IN.
  - Word k is presented at T+1+k.
  - WAIT is entered at T+1+NUM_IN.
- If the mask becomes complete in cycle C, counting bits captured in C itself, `out_valid`=1 from cycle C+1.
- If the handshake completes in cycle H, `in_ready`=1 from H+1. There is no same-cycle bypass, so the minimum gap between frames is one cycle.
- `out_ready` held high before `out_valid` completes the handshake in the first HOLD cycle.
- `rst` mid-frame: IDLE next cycle, `lyr_valid_input` drops immediately, and the partial frame is discarded.

## Configuration
- `LAYER_SEQ_PERF_CNT_EN` defined:
  - A 32-bit counter clears on accept and increments every cycle through SHIFT and WAIT.
  - On the WAIT→HOLD transition its value is loaded into `perf_cycles`.
  - The counter saturates at 2^32-1.
- Not defined: `perf_cycles` is tied to 0 and no counter logic is built.

## Structure
- Shared package `layer_seq_pkg` holds:
  - the state enum (IDLE, SHIFT, WAIT, HOLD);
  - a `DATA_WIDTH` default;
  - a slice-offset helper function.
- One sub-module: `layer_seq_serializer`, which contains the frame buffer, word index and `lyr_input`/`lyr_valid_input` generation, with a start input and a done output. Capture logic, FSM and perf counter stay in the top level.

## Test plan
- NUM_IN=10: frame with word k = 16'h0100+k accepted at T → `lyr_valid_input` is high T+1..T+10 and `lyr_input` shows 0x0100..0x0109 in order; `in_ready`=0 during T+1..T+10.
- Neurons 0..9 pulse in separate cycles with value 16'h0A00+i → `out_valid` rises the cycle after the last pulse, and `out_data` slice i = 0x0A00+i.
- All 10 bits pulse in the same cycle, with `out_ready` held 0 for 5 cycles → `out_valid` stays high with stable data for 5 cycles; `in_ready`=1 the cycle after the handshake.
- Bit 3 pulses twice with values 0x1111 then 0x2222 → `err`=1 and slice 3 = 0x1111; a pulse while IDLE also sets `err`.
- `rst` asserted at word 4 of SHIFT → next cycle `lyr_valid_input`=0, `busy`=0, `in_ready`=1; a following frame completes normally.
- With `LAYER_SEQ_PERF_CNT_EN` and the last neuron pulsing 20 cycles after WAIT entry → `perf_cycles` = 10 + 20 + 1 = 31.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the layer sequencer.
// No logic; state encoding, default word width and packed-slice offset helper.
// Backpressure: n/a.
package layer_seq_pkg;

    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Low bit of word idx inside a packed vector of width-bit words.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/layer_seq_serializer.sv
// Latches a parallel frame on start and issues it one word per cycle.
// Latency: word 0 the cycle after start, then NUM_IN back-to-back words; done marks the last.
// Backpressure: none, the layer consumes every word it is given.
module layer_seq_serializer
    import layer_seq_pkg::*;
#(
    parameter int NUM_IN     = 10,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_IN*DATA_WIDTH-1:0] frame,
    output logic [DATA_WIDTH-1:0]        lyr_input,
    output logic                         lyr_valid_input,
    output logic                         done
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    logic [DATA_WIDTH-1:0] words [NUM_IN];
    logic [IDX_W-1:0]      idx;
    logic                  run;

    // Frame buffer needs no reset: its contents are only visible while run is high.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int k = 0; k < NUM_IN; k++) begin
                words[k] <= frame[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            idx <= '0;
        end else if (start) begin
            run <= 1'b1;
            idx <= '0;
        end else if (run) begin
            if (idx == LAST_IDX) begin
                run <= 1'b0;
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign lyr_input       = run ? words[idx] : '0;
    assign lyr_valid_input = run;
    assign done            = run && (idx == LAST_IDX);

endmodule

// File: rtl/layer_sequencer.sv
// Feeds one neuron layer a frame word-by-word, gathers every neuron result, presents the output frame.
// Latency: NUM_IN shift cycles, then out_valid the cycle after the last neuron result lands.
// Backpressure: in_ready only in IDLE; output held in HOLD until out_ready. LAYER_SEQ_PERF_CNT_EN adds a frame cycle counter.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int NUM_IN     = 10,
    parameter int NUM_OUT    = 10,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
    output logic [DATA_WIDTH-1:0]         lyr_input,
    output logic                          lyr_valid_input,
    input  logic [NUM_OUT-1:0]            lyr_valid_output,
    input  logic [NUM_OUT*DATA_WIDTH-1:0] lyr_neuron_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic                          busy,
    output logic                          err,
    output logic [31:0]                   perf_cycles
);

    state_t             state_q, state_d;
    logic               accept;
    logic               collect;
    logic               ser_done;
    logic [NUM_OUT-1:0] mask_q;
    logic               mask_full;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign collect   = (state_q == SHIFT) || (state_q == WAIT);
    // Bits landing this cycle count towards completion so out_valid follows one cycle later.
    assign mask_full = &(mask_q | lyr_valid_output);

    layer_seq_serializer #(
        .NUM_IN     (NUM_IN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk             (clk),
        .rst             (rst),
        .start           (accept),
        .frame           (in_data),
        .lyr_input       (lyr_input),
        .lyr_valid_input (lyr_valid_input),
        .done            (ser_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                 state_d = SHIFT;
            SHIFT:   if (ser_done)               state_d = WAIT;
            WAIT:    if (mask_full)              state_d = HOLD;
            HOLD:    if (out_valid && out_ready) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= '0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                mask_q <= '0;
            end else if (collect) begin
                // First pulse per neuron wins; repeats only raise err.
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (lyr_valid_output[i] && !mask_q[i]) begin
                        mask_q[i] <= 1'b1;
                        out_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] <=
                            lyr_neuron_out[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
                    end
                end
            end
            if ((!collect && (|lyr_valid_output)) ||
                (collect && (|(lyr_valid_output & mask_q)))) begin
                err <= 1'b1;
            end
        end
    end

`ifdef LAYER_SEQ_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] cyc_inc;

    assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

    // The completing cycle itself is counted, hence the incremented value is latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q       <= '0;
            perf_cycles <= '0;
        end else begin
            if (accept) begin
                cyc_q <= '0;
            end else if (collect) begin
                cyc_q <= cyc_inc;
            end
            if ((state_q == WAIT) && mask_full) begin
                perf_cycles <= cyc_inc;
            end
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: frame shift-in, result collection, handshake, errors, reset.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
module tb_layer_sequencer;

    localparam int NI = 10;
    localparam int NO = 10;
    localparam int DW = 16;
`ifdef LAYER_SEQ_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [NI*DW-1:0]  in_data;
    logic [DW-1:0]     lyr_input;
    logic              lyr_valid_input;
    logic [NO-1:0]     lyr_valid_output;
    logic [NO*DW-1:0]  lyr_neuron_out;
    logic              out_valid;
    logic              out_ready;
    logic [NO*DW-1:0]  out_data;
    logic              busy;
    logic              err;
    logic [31:0]       perf_cycles;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .lyr_input        (lyr_input),
        .lyr_valid_input  (lyr_valid_input),
        .lyr_valid_output (lyr_valid_output),
        .lyr_neuron_out   (lyr_neuron_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .busy             (busy),
        .err              (err),
        .perf_cycles      (perf_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] oslice(input int i);
        return out_data[i*DW +: DW];
    endfunction

    // Offers a frame for one cycle; returns one cycle after acceptance (word 0 on the bus).
    task automatic send_frame(input logic [DW-1:0] base);
        for (int k = 0; k < NI; k++) in_data[k*DW +: DW] = DW'(base + k);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < NI; k++) in_data[k*DW +: DW] = 16'hBEEF;
    endtask

    task automatic pulse(input logic [NO-1:0] bits, input logic [DW-1:0] base);
        lyr_valid_output = bits;
        for (int i = 0; i < NO; i++) lyr_neuron_out[i*DW +: DW] = bits[i] ? DW'(base + i) : 16'hDEAD;
        tick();
        lyr_valid_output = '0;
        lyr_neuron_out   = '1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_out_valid", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        lyr_valid_output = '0; lyr_neuron_out = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_vin", lyr_valid_input, 0);
        chk("rst_lyr_input", lyr_input, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data_zero", (out_data == '0), 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_perf", perf_cycles, 0);

        // Frame 1: shift-in order, then one neuron per cycle.
        send_frame(16'h0100);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("f1_vin_%0d", k), lyr_valid_input, 1);
            chk($sformatf("f1_word_%0d", k), lyr_input, 64'(16'h0100 + k));
            chk($sformatf("f1_in_ready_%0d", k), in_ready, 0);
            tick();
        end
        chk("f1_vin_end", lyr_valid_input, 0);
        chk("f1_busy_wait", busy, 1);
        for (int i = 0; i < NO; i++) begin
            pulse(NO'(1) << i, 16'h0A00);
            chk($sformatf("f1_out_valid_after_%0d", i), out_valid, (i == NO - 1) ? 1 : 0);
        end
        for (int i = 0; i < NO; i++) chk($sformatf("f1_slice_%0d", i), oslice(i), 64'(16'h0A00 + i));
        chk("f1_perf", perf_cycles, PERF_ON ? 20 : 0);
        chk("f1_err", err, 0);
        handshake();

        // Frame 2: all neurons at once, downstream stalls five cycles.
        send_frame(16'h0200);
        repeat (NI) tick();
        pulse('1, 16'h0B00);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("f2_hold_valid_%0d", c), out_valid, 1);
            chk($sformatf("f2_hold_s0_%0d", c), oslice(0), 16'h0B00);
            chk($sformatf("f2_hold_s9_%0d", c), oslice(9), 16'h0B09);
            chk($sformatf("f2_hold_in_ready_%0d", c), in_ready, 0);
            tick();
        end
        chk("f2_perf", perf_cycles, PERF_ON ? 11 : 0);
        handshake();

        // Frame 3: duplicate pulse on neuron 3; out_ready already high when HOLD begins.
        send_frame(16'h0300);
        repeat (NI) tick();
        pulse(NO'(1) << 3, 16'h1111 - 16'd3);
        chk("f3_err_clean", err, 0);
        pulse(NO'(1) << 3, 16'h2222 - 16'd3);
        chk("f3_err_dup", err, 1);
        out_ready = 1'b1;
        pulse(~(NO'(1) << 3), 16'h0C00);
        chk("f3_out_valid", out_valid, 1);
        chk("f3_slice3", oslice(3), 16'h1111);
        chk("f3_slice0", oslice(0), 16'h0C00);
        chk("f3_slice9", oslice(9), 16'h0C09);
        tick();
        out_ready = 1'b0;
        chk("f3_hs_out_valid", out_valid, 0);
        chk("f3_hs_in_ready", in_ready, 1);

        // Stray pulse while IDLE.
        rst = 1'b1; tick(); rst = 1'b0;
        chk("idle_err_cleared", err, 0);
        pulse(NO'(1) << 5, 16'h0D00);
        chk("idle_err_set", err, 1);
        rst = 1'b1; tick(); rst = 1'b0;

        // Reset mid-shift at word 4, then a full frame with a late last neuron.
        send_frame(16'h0400);
        repeat (4) tick();
        chk("mid_word4", lyr_input, 16'h0404);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_vin", lyr_valid_input, 0);
        chk("mid_busy", busy, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_err", err, 0);

        send_frame(16'h0500);
        chk("f5_word0", lyr_input, 16'h0500);
        repeat (NI) tick();
        pulse(NO'(10'h1FF), 16'h0E00);
        repeat (19) tick();
        chk("f5_not_yet", out_valid, 0);
        pulse(NO'(1) << 9, 16'h0E00);
        chk("f5_out_valid", out_valid, 1);
        chk("f5_slice0", oslice(0), 16'h0E00);
        chk("f5_slice9", oslice(9), 16'h0E09);
        chk("f5_perf", perf_cycles, PERF_ON ? 31 : 0);
        chk("f5_err", err, 0);
        handshake();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
